// File: rtl/c432_resp_compactor.sv
// c432_resp_compactor
//   Response-capture stage behind the c432 netlist. Each accepted vector's
//   seven primary outputs are folded into a 16-bit MISR signature. A per-output
//   ones counter records how often each output was 1. A session covers
//   num_vectors accepts and then holds in DONE. While in DONE, the signature is
//   compared against golden_sig.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          begin a session (honoured in IDLE / DONE)
//   num_vectors    vectors per session, sampled on accepted start
//   golden_sig     expected signature, compared while in DONE
//   resp_valid     resp carries one vector's outputs
//   resp           {N432,N431,N430,N421,N370,N329,N223}, bit0 = N223
//   resp_ready     high only in RUN
//   done           high in DONE
//   match          DONE & (signature == golden_sig)
//   signature      current MISR state
//   vec_count      vectors accepted this session
//   ones_count     lane i (CNT_W bits at i*CNT_W) = accepts with resp[i]=1

// One ones-counter lane. It is cleared on session start and bumped on an
// accept that carries a 1 on this lane.
module c432_ones_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end
endmodule

module c432_resp_compactor #(
  parameter int          CNT_W = 16,
  parameter logic [15:0] POLY  = 16'h100B,
  parameter logic [15:0] SEED  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vectors,
  input  logic [15:0]          golden_sig,
  input  logic                 resp_valid,
  input  logic [6:0]           resp,
  output logic                 resp_ready,
  output logic                 done,
  output logic                 match,
  output logic [15:0]          signature,
  output logic [CNT_W-1:0]     vec_count,
  output logic [7*CNT_W-1:0]   ones_count
);
  localparam int NUM_LANES = 7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] target;
  logic             start_acc;
  logic             accept;
  logic             last_acc;
  logic [15:0]      sig_next;

  logic [NUM_LANES-1:0][CNT_W-1:0] ones_q;
  logic [NUM_LANES-1:0]            lane_inc;

  // start is ignored in RUN, so a pulse mid-session cannot restart it.
  assign start_acc = start && (state == S_IDLE || state == S_DONE);
  assign accept    = resp_valid && (state == S_RUN);
  // target is never 0 in RUN, so target-1 cannot wrap.
  assign last_acc  = accept && (vec_count == target - 1'b1);

  // Shift left. When the bit falling out of the MSB is 1, fold POLY back in.
  // Then XOR the response into the low bits.
  always_comb begin
    sig_next = {signature[14:0], 1'b0} ^ (signature[15] ? POLY : 16'h0000);
    sig_next = sig_next ^ {9'b0, resp};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      target    <= '0;
      signature <= 16'h0000;
      vec_count <= '0;
    end else if (start_acc) begin
      state     <= (num_vectors == '0) ? S_DONE : S_RUN;
      target    <= num_vectors;
      signature <= SEED;
      vec_count <= '0;
    end else if (accept) begin
      signature <= sig_next;
      vec_count <= vec_count + 1'b1;
      if (last_acc) state <= S_DONE;
    end
  end

  assign lane_inc = resp & {NUM_LANES{accept}};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    c432_ones_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_acc),
      .inc   (lane_inc[i]),
      .count (ones_q[i])
    );
  end

  assign ones_count = ones_q;
  assign resp_ready = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign match      = (state == S_DONE) && (signature == golden_sig);
endmodule

// File: tb/tb_c432_resp_compactor.sv
module tb_c432_resp_compactor;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vectors;
  logic [15:0] golden_sig;
  logic        resp_valid;
  logic [6:0]  resp;

  logic        resp_ready, done, match;
  logic [15:0] signature, vec_count;
  logic [111:0] ones_count;

  logic        b_resp_ready, b_done, b_match;
  logic [15:0] b_signature, b_vec_count;
  logic [111:0] b_ones_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  c432_resp_compactor dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .golden_sig(golden_sig), .resp_valid(resp_valid), .resp(resp),
    .resp_ready(resp_ready), .done(done), .match(match),
    .signature(signature), .vec_count(vec_count), .ones_count(ones_count)
  );

  // Seeded instance for the MISR feedback path.
  c432_resp_compactor #(.SEED(16'h8000)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .golden_sig(golden_sig), .resp_valid(resp_valid), .resp(resp),
    .resp_ready(b_resp_ready), .done(b_done), .match(b_match),
    .signature(b_signature), .vec_count(b_vec_count), .ones_count(b_ones_count)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; resp_valid = 1'b1; resp = 7'h7F;
    num_vectors = 16'd5; golden_sig = 16'h0000;
    tick(); tick();
    nvec++; if (signature !== 16'h0000) begin nerr++; $display("FAIL reset_sig got %h want 0000", signature); end
    nvec++; if (vec_count !== 16'd0) begin nerr++; $display("FAIL reset_vec got %0d want 0", vec_count); end
    nvec++; if (ones_count !== 112'd0) begin nerr++; $display("FAIL reset_ones got %h want 0", ones_count); end
    nvec++; if ({resp_ready, done, match} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {resp_ready, done, match}); end
    nvec++; if (b_signature !== 16'h0000) begin nerr++; $display("FAIL reset_sig_b got %h want 0000", b_signature); end
    rst = 1'b0; start = 1'b0; resp_valid = 1'b0; resp = 7'h00;
    tick();
    nvec++; if (resp_ready !== 1'b0) begin nerr++; $display("FAIL idle_ready got %b want 0", resp_ready); end
  endtask

  task automatic test_basic();
    start = 1'b1; num_vectors = 16'd2; tick(); start = 1'b0;
    nvec++; if (resp_ready !== 1'b1) begin nerr++; $display("FAIL basic_ready got %b want 1", resp_ready); end
    resp_valid = 1'b1; resp = 7'h01; tick();
    nvec++; if (signature !== 16'h0001) begin nerr++; $display("FAIL basic_sig1 got %h want 0001", signature); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL basic_done_early got %b want 0", done); end
    tick(); resp_valid = 1'b0; resp = 7'h00;
    nvec++; if (signature !== 16'h0003) begin nerr++; $display("FAIL basic_sig2 got %h want 0003", signature); end
    nvec++; if (vec_count !== 16'd2) begin nerr++; $display("FAIL basic_vec got %0d want 2", vec_count); end
    nvec++; if (ones_count !== 112'd2) begin nerr++; $display("FAIL basic_ones got %h want 2 in lane0 only", ones_count); end
    nvec++; if ({done, resp_ready} !== 2'b10) begin nerr++; $display("FAIL basic_done got %b want 10", {done, resp_ready}); end
    nvec++; if (match !== 1'b0) begin nerr++; $display("FAIL basic_nomatch got %b want 0", match); end
    golden_sig = 16'h0003; #1;
    nvec++; if (match !== 1'b1) begin nerr++; $display("FAIL basic_match got %b want 1", match); end
  endtask

  task automatic test_feedback();
    // Also checks that a start while in DONE clears done and match.
    start = 1'b1; num_vectors = 16'd1; tick(); start = 1'b0;
    nvec++; if ({done, match} !== 2'b00) begin nerr++; $display("FAIL fb_clear got %b want 00", {done, match}); end
    nvec++; if (b_signature !== 16'h8000) begin nerr++; $display("FAIL fb_seed got %h want 8000", b_signature); end
    resp_valid = 1'b1; resp = 7'h00; tick(); resp_valid = 1'b0;
    golden_sig = 16'h100C; #1;
    nvec++; if (b_signature !== 16'h100B) begin nerr++; $display("FAIL fb_sig got %h want 100B", b_signature); end
    nvec++; if ({b_done, b_match} !== 2'b10) begin nerr++; $display("FAIL fb_match got %b want 10", {b_done, b_match}); end
    golden_sig = 16'h100B; #1;
    nvec++; if (b_match !== 1'b1) begin nerr++; $display("FAIL fb_match_eq got %b want 1", b_match); end
  endtask

  task automatic test_zero();
    start = 1'b1; num_vectors = 16'd0; golden_sig = 16'h0000; tick(); start = 1'b0;
    nvec++; if ({done, resp_ready} !== 2'b10) begin nerr++; $display("FAIL zero_done got %b want 10", {done, resp_ready}); end
    nvec++; if (signature !== 16'h0000) begin nerr++; $display("FAIL zero_sig got %h want 0000", signature); end
    nvec++; if (b_signature !== 16'h8000) begin nerr++; $display("FAIL zero_sig_b got %h want 8000", b_signature); end
    nvec++; if (match !== 1'b1) begin nerr++; $display("FAIL zero_match got %b want 1", match); end
    resp_valid = 1'b1; resp = 7'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (resp_ready !== 1'b0 || vec_count !== 16'd0) begin nerr++; $display("FAIL zero_ignore got ready=%b vec=%0d want 0/0", resp_ready, vec_count); end
    end
    resp_valid = 1'b0;
  endtask

  task automatic test_stalls();
    logic [6:0] pat [0:5];
    logic       vld [0:5];
    logic       stp [0:5];
    pat = '{7'h05, 7'h00, 7'h02, 7'h00, 7'h00, 7'h40};
    vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    stp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    start = 1'b1; num_vectors = 16'd3; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      resp_valid = vld[i]; resp = pat[i]; start = stp[i]; num_vectors = 16'd1;
      tick();
    end
    resp_valid = 1'b0; start = 1'b0;
    // 0005 -> 000A^02=0008 -> 0010^40=0050
    nvec++; if (signature !== 16'h0050) begin nerr++; $display("FAIL stall_sig got %h want 0050", signature); end
    nvec++; if (vec_count !== 16'd3) begin nerr++; $display("FAIL stall_vec got %0d want 3", vec_count); end
    nvec++; if (ones_count[15:0] !== 16'd1 || ones_count[31:16] !== 16'd1 || ones_count[47:32] !== 16'd1 ||
                ones_count[95:48] !== 48'd0 || ones_count[111:96] !== 16'd1)
      begin nerr++; $display("FAIL stall_ones got %h want lanes0,1,2,6 = 1", ones_count); end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL stall_done got %b want 1", done); end
    resp_valid = 1'b1; resp = 7'h7F; tick(); resp_valid = 1'b0;
    nvec++; if (signature !== 16'h0050 || vec_count !== 16'd3) begin nerr++; $display("FAIL stall_post got sig=%h vec=%0d want 0050/3", signature, vec_count); end
    nvec++; if (ones_count[79:64] !== 16'd0) begin nerr++; $display("FAIL stall_post_ones got %0d want 0", ones_count[79:64]); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; num_vectors = 16'd3; tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 7'h11; tick(); resp_valid = 1'b0;
    nvec++; if (vec_count !== 16'd1) begin nerr++; $display("FAIL mid_vec got %0d want 1", vec_count); end
    rst = 1'b1; tick(); rst = 1'b0;
    nvec++; if ({signature, vec_count} !== 32'd0 || ones_count !== 112'd0) begin nerr++; $display("FAIL mid_clear got sig=%h vec=%0d", signature, vec_count); end
    nvec++; if ({resp_ready, done, match} !== 3'b000) begin nerr++; $display("FAIL mid_flags got %b want 000", {resp_ready, done, match}); end
    start = 1'b1; num_vectors = 16'd1; tick(); start = 1'b0;
    resp_valid = 1'b1; resp = 7'h7F; tick(); resp_valid = 1'b0;
    nvec++; if (signature !== 16'h007F) begin nerr++; $display("FAIL fresh_sig got %h want 007F", signature); end
    for (int i = 0; i < 7; i++) begin
      nvec++; if (ones_count[i*16 +: 16] !== 16'd1) begin nerr++; $display("FAIL fresh_ones lane %0d got %0d want 1", i, ones_count[i*16 +: 16]); end
    end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL fresh_done got %b want 1", done); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_feedback();
    test_zero();
    test_stalls();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
